// File: rtl/bsg_decode_scoreboard_if.sv
// Set/clear request and occupancy status bundle for bsg_decode_scoreboard.
// master = requester side, slave = scoreboard side.
interface bsg_decode_scoreboard_if #(
  parameter int els_p = 128
);
  localparam int lg_els_lp = (els_p <= 1) ? 1 : $clog2(els_p);

  logic                 set_v_i;
  logic [lg_els_lp-1:0] set_idx_i;
  logic                 set_ready_o;
  logic                 clr_v_i;
  logic [lg_els_lp-1:0] clr_idx_i;
  logic [els_p-1:0]     busy_o;
  logic [lg_els_lp:0]   count_o;
  logic                 empty_o;
  logic                 full_o;
  logic                 err_o;

  modport master (
    output set_v_i, set_idx_i, clr_v_i, clr_idx_i,
    input  set_ready_o, busy_o, count_o, empty_o, full_o, err_o
  );

  modport slave (
    input  set_v_i, set_idx_i, clr_v_i, clr_idx_i,
    output set_ready_o, busy_o, count_o, empty_o, full_o, err_o
  );
endinterface

// File: rtl/bsg_decode_scoreboard.sv
// Registered occupancy scoreboard: binary set/clear indices are decoded to
// one-hot updates of a persistent busy vector, with a running count,
// full/empty flags and a sticky error flag for illegal requests.
module bsg_decode_scoreboard #(
  parameter int els_p        = 128,
  parameter bit clr_bypass_p = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  bsg_decode_scoreboard_if.slave        io
);
  localparam int lg_els_lp = (els_p <= 1) ? 1 : $clog2(els_p);
  localparam logic [lg_els_lp:0] els_w_lp = (lg_els_lp+1)'(els_p);

  logic [els_p-1:0]     busy_q, busy_d;
  logic [lg_els_lp:0]   count_q, count_d;
  logic                 err_q, err_d;

  logic [els_p-1:0]     set_dec, clr_dec;
  logic                 set_in_range, clr_in_range;
  logic                 set_busy, clr_busy;
  logic                 set_ready, set_acc, clr_eff;

  // Index decode without valid; an out-of-range index yields all zeros, so
  // the busy lookups below never index past the vector.
  always_comb begin
    set_dec = '0;
    clr_dec = '0;
    for (int i = 0; i < els_p; i++) begin
      set_dec[i] = (io.set_idx_i == lg_els_lp'(i));
      clr_dec[i] = (io.clr_idx_i == lg_els_lp'(i));
    end
  end

  assign set_in_range = ({1'b0, io.set_idx_i} < els_w_lp);
  assign clr_in_range = ({1'b0, io.clr_idx_i} < els_w_lp);
  assign set_busy     = |(busy_q & set_dec);
  assign clr_busy     = |(busy_q & clr_dec);

  // Ready looks only at state and the clear port, never at set_v_i.
  assign set_ready = set_in_range
                   & (~set_busy
                      | (clr_bypass_p & io.clr_v_i & (io.clr_idx_i == io.set_idx_i)));
  assign set_acc   = io.set_v_i & set_ready;
  assign clr_eff   = io.clr_v_i & clr_busy;

  // Next-state: clear applied before set, so a bypassed same-index pair stays busy.
  always_comb begin
    busy_d = busy_q;
    if (io.clr_v_i) busy_d = busy_d & ~clr_dec;
    if (set_acc)    busy_d = busy_d | set_dec;

    count_d = count_q;
    case ({set_acc, clr_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    err_d = err_q
          | (io.clr_v_i & ~clr_busy)
          | (io.clr_v_i & ~clr_in_range)
          | (io.set_v_i & ~set_in_range);
  end

  // State registers; reset overrides any same-cycle request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign io.set_ready_o = set_ready;
  assign io.busy_o      = busy_q;
  assign io.count_o     = count_q;
  assign io.empty_o     = (count_q == '0);
  assign io.full_o      = (count_q == els_w_lp);
  assign io.err_o       = err_q;

`ifndef SYNTHESIS
  // Count register must always agree with the population of the busy vector.
  always @(posedge clk_i) begin
    if (!reset_i)
      assert ($countones(busy_q) == int'(count_q))
        else $error("count_o %0d disagrees with busy_o popcount %0d",
                    count_q, $countones(busy_q));
  end
`endif
endmodule
